countdown_engine: RTL and testbench

Countdown datapath for the egg timer: holds the MM:SS value, loads it from the switch validator during setting, and decrements it once per second while the timer controller asserts decrement enable. It also drives the time-flat flag back to the controller and the blinking LED output. It sits between the timer controller (enables, set strobes) and the display/LED outputs.

---
 rtl/egg_timer_pkg.sv | 28 ++
 rtl/countdown_engine_if.sv | 27 ++
 rtl/tick_prescaler.sv | 39 +++
 rtl/countdown_engine.sv | 90 +++++++++
 tb/tb_countdown_engine.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/egg_timer_pkg.sv
// Shared egg-timer constants: field widths, limits, controller state encoding
// and the switch-value clamp helpers used when loading MM:SS.
package egg_timer_pkg;

   localparam int unsigned SW_W    = 7;
   localparam int unsigned SEC_W   = 6;
   localparam int unsigned MIN_W   = 7;
   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 99;

   typedef enum logic [2:0] {
      StIdle,
      StSetSec,
      StSetMin,
      StRun,
      StPause,
      StFlat
   } timer_state_e;

   function automatic logic [SEC_W-1:0] clamp_sec(input logic [SW_W-1:0] v);
      return (32'(v) > SEC_MAX) ? SEC_W'(SEC_MAX) : v[SEC_W-1:0];
   endfunction

   function automatic logic [MIN_W-1:0] clamp_min(input logic [SW_W-1:0] v);
      return (32'(v) > MIN_MAX) ? MIN_W'(MIN_MAX) : MIN_W'(v);
   endfunction

endpackage

// File: rtl/countdown_engine_if.sv
// Controller <-> countdown datapath signal bundle. The controller is the master;
// the countdown engine is the slave.
interface countdown_engine_if;
   import egg_timer_pkg::*;

   logic [SW_W-1:0]  sw_value;
   logic             load_sec;
   logic             load_min;
   logic             dec_en;
   logic             flash_en;
   logic [SEC_W-1:0] secs;
   logic [MIN_W-1:0] mins;
   logic             tick;
   logic             time_flat;
   logic             led;

   modport master (
      output sw_value, load_sec, load_min, dec_en, flash_en,
      input  secs, mins, tick, time_flat, led
   );

   modport slave (
      input  sw_value, load_sec, load_min, dec_en, flash_en,
      output secs, mins, tick, time_flat, led
   );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter with synchronous clear; wrap_pulse_o is high for
// the single counting cycle in which the counter sits at DIV-1.
module tick_prescaler #(
   parameter int unsigned DIV = 4
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic wrap_pulse_o
);

   localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            at_max;

   assign at_max       = (cnt_q == CntMax);
   assign wrap_pulse_o = en_i & ~clr_i & at_max;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = at_max ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/countdown_engine.sv
// MM:SS countdown datapath: clamped loads while idle, 1-per-TICK_DIV decrement
// with minute borrow, time-flat detect and the flashing LED drive.
module countdown_engine
   import egg_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50000000,
   parameter int unsigned BLINK_DIV = 12500000
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   countdown_engine_if.slave  bus
);

   logic [SEC_W-1:0] secs_q, secs_d;
   logic [MIN_W-1:0] mins_q, mins_d;
   logic             phase_q, phase_d;
   logic             time_flat;
   logic             count_en;
   logic             tick;
   logic             blink_wrap;

   assign time_flat = (secs_q == '0) && (mins_q == '0);
   // Stopping at 00:00 also holds the prescaler clear, so no tick can underflow.
   assign count_en  = bus.dec_en & ~time_flat;

   tick_prescaler #(
      .DIV (TICK_DIV)
   ) u_tick_prescaler (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .en_i         (count_en),
      .clr_i        (~count_en),
      .wrap_pulse_o (tick)
   );

   tick_prescaler #(
      .DIV (BLINK_DIV)
   ) u_blink_prescaler (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .en_i         (bus.flash_en),
      .clr_i        (~bus.flash_en),
      .wrap_pulse_o (blink_wrap)
   );

   always_comb begin
      secs_d = secs_q;
      mins_d = mins_q;
      if (!bus.dec_en) begin
         if (bus.load_sec) secs_d = clamp_sec(bus.sw_value);
         if (bus.load_min) mins_d = clamp_min(bus.sw_value);
      end else if (tick) begin
         if (secs_q != '0) begin
            secs_d = secs_q - 1'b1;
         end else if (mins_q != '0) begin
            secs_d = SEC_W'(SEC_MAX);
            mins_d = mins_q - 1'b1;
         end
      end
   end

   always_comb begin
      phase_d = phase_q;
      if (!bus.flash_en) begin
         phase_d = 1'b0;
      end else if (blink_wrap) begin
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         secs_q  <= '0;
         mins_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         secs_q  <= secs_d;
         mins_q  <= mins_d;
         phase_q <= phase_d;
      end
   end

   assign bus.secs      = secs_q;
   assign bus.mins      = mins_q;
   assign bus.tick      = tick;
   assign bus.time_flat = time_flat;
   // Combinational so the LED lights in the very first flash cycle.
   assign bus.led       = bus.flash_en & ~phase_q;

endmodule

// File: tb/tb_countdown_engine.sv
// Directed bench for countdown_engine with TICK_DIV=4, BLINK_DIV=3.
module tb_countdown_engine;

   logic clk;
   logic reset_ni;
   int   n_checks;
   int   n_fails;

   countdown_engine_if bus ();

   countdown_engine #(
      .TICK_DIV  (4),
      .BLINK_DIV (3)
   ) dut (
      .clk_i    (clk),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input bit ls, input bit lm, input int val);
      bus.sw_value = 7'(val);
      bus.load_sec = ls;
      bus.load_min = lm;
      next_cycle();
      bus.load_sec = 1'b0;
      bus.load_min = 1'b0;
      #1;
   endtask

   task automatic check_time(input string tag, input int m, input int s);
      check_eq({tag, ".mins"}, int'(bus.mins), m);
      check_eq({tag, ".secs"}, int'(bus.secs), s);
   endtask

   int exp_led [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};

   initial begin
      n_checks     = 0;
      n_fails      = 0;
      reset_ni     = 1'b0;
      bus.sw_value = '0;
      bus.load_sec = 1'b0;
      bus.load_min = 1'b0;
      bus.dec_en   = 1'b0;
      bus.flash_en = 1'b0;

      // Reset state
      #12;
      check_time("rst", 0, 0);
      check_eq("rst.tick", int'(bus.tick), 0);
      check_eq("rst.led", int'(bus.led), 0);
      check_eq("rst.time_flat", int'(bus.time_flat), 1);
      reset_ni = 1'b1;
      next_cycle();
      check_time("idle", 0, 0);

      // Clamped loads
      load(1'b1, 1'b0, 75);
      check_eq("clamp.secs", int'(bus.secs), 59);
      load(1'b0, 1'b1, 120);
      check_eq("clamp.mins", int'(bus.mins), 99);

      // 01:02 with borrow
      load(1'b1, 1'b0, 2);
      load(1'b0, 1'b1, 1);
      check_time("ld0102", 1, 2);
      bus.dec_en = 1'b1;
      #1;
      for (int c = 1; c <= 12; c++) begin
         check_eq($sformatf("run.tick%0d", c), int'(bus.tick), (c % 4 == 0) ? 1 : 0);
         next_cycle();
         if (c == 4)  check_time("run.t1", 1, 1);
         if (c == 8)  check_time("run.t2", 1, 0);
         if (c == 12) check_time("run.t3", 0, 59);
         check_eq($sformatf("run.flat%0d", c), int'(bus.time_flat), 0);
      end
      bus.dec_en = 1'b0;
      #1;

      // 00:02 down to 00:00 and stay there
      load(1'b1, 1'b0, 2);
      load(1'b0, 1'b1, 0);
      check_time("ld0002", 0, 2);
      bus.dec_en = 1'b1;
      #1;
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         if (c == 4) check_time("end.t1", 0, 1);
         if (c == 7) check_eq("end.flat_pre", int'(bus.time_flat), 0);
      end
      check_time("end.zero", 0, 0);
      check_eq("end.flat", int'(bus.time_flat), 1);
      for (int c = 1; c <= 20; c++) begin
         check_eq($sformatf("end.notick%0d", c), int'(bus.tick), 0);
         next_cycle();
      end
      check_time("end.hold", 0, 0);
      bus.dec_en = 1'b0;
      #1;

      // Pause mid-second, ignored load while running
      load(1'b1, 1'b0, 10);
      check_time("ld0010", 0, 10);
      bus.dec_en = 1'b1;
      next_cycle();
      next_cycle();
      bus.dec_en = 1'b0;
      for (int c = 1; c <= 5; c++) next_cycle();
      check_time("pause.hold", 0, 10);
      bus.dec_en = 1'b1;
      #1;
      for (int c = 1; c <= 4; c++) begin
         check_eq($sformatf("resume.tick%0d", c), int'(bus.tick), (c == 4) ? 1 : 0);
         if (c == 2) begin
            bus.sw_value = 7'd30;
            bus.load_sec = 1'b1;
         end
         next_cycle();
         bus.load_sec = 1'b0;
         if (c == 2) check_time("resume.noload", 0, 10);
      end
      check_time("resume.t1", 0, 9);
      bus.dec_en = 1'b0;
      #1;

      // Dual load, then asynchronous reset mid-run
      load(1'b1, 1'b1, 45);
      check_time("dual", 45, 45);
      bus.dec_en = 1'b1;
      for (int c = 1; c <= 20; c++) next_cycle();
      check_time("run45", 45, 40);
      next_cycle();
      next_cycle();
      #2;
      reset_ni = 1'b0;
      #1;
      check_time("arst", 0, 0);
      check_eq("arst.tick", int'(bus.tick), 0);
      check_eq("arst.led", int'(bus.led), 0);
      check_eq("arst.flat", int'(bus.time_flat), 1);
      bus.dec_en = 1'b0;
      next_cycle();
      reset_ni = 1'b1;
      next_cycle();
      check_time("post_rst", 0, 0);

      // LED blink
      bus.flash_en = 1'b1;
      #1;
      for (int c = 0; c < 12; c++) begin
         check_eq($sformatf("led%0d", c), int'(bus.led), exp_led[c]);
         next_cycle();
      end
      bus.flash_en = 1'b0;
      next_cycle();
      check_eq("led.off", int'(bus.led), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
